// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (read-only) and data
// (read/write) requesters, one transaction in flight, data priority with a
// fetch starvation guard.
// Ports: clk, rst (async, active high); i_* fetch side; d_* data side;
// m_* memory side. Optional TOHOST_MON_EN adds done/result monitor outputs.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] DONE_ADDR = 32'h80001004,
  parameter logic [ADDR_W-1:0] RESULT_ADDR = 32'h80001000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
`ifdef TOHOST_MON_EN
  ,
  output logic              done,
  output logic [DATA_W-1:0] result
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_e;

  state_e state_q;
  logic owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic m_req_q, m_we_q;
  logic [BE_W-1:0] m_be_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic i_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic idle, starved, f_win, d_win;

  // Grants are combinational so the winner sees gnt in its win cycle.
  assign idle = (state_q == IDLE);
  assign starved = (cnt_q == SMAX);
  assign f_win = idle & i_req & (~d_req | starved);
  assign d_win = idle & d_req & ~f_win;

  assign i_gnt = f_win;
  assign d_gnt = d_win;
  assign i_rvalid = i_rvalid_q;
  assign i_rdata = i_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata = d_rdata_q;
  assign m_req = m_req_q;
  assign m_we = m_we_q;
  assign m_be = m_be_q;
  assign m_addr = m_addr_q;
  assign m_wdata = m_wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q <= '0;
      m_req_q <= 1'b0;
      m_we_q <= 1'b0;
      m_be_q <= '0;
      m_addr_q <= '0;
      m_wdata_q <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      // Response outputs live only for the single RESP cycle.
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (f_win) begin
            state_q <= REQ;
            owner_q <= 1'b0;
            m_req_q <= 1'b1;
            m_we_q <= 1'b0;
            m_be_q <= '1;
            m_addr_q <= i_addr;
            m_wdata_q <= '0;
            cnt_q <= '0;
          end else if (d_win) begin
            state_q <= REQ;
            owner_q <= 1'b1;
            m_req_q <= 1'b1;
            m_we_q <= d_we;
            m_be_q <= d_be;
            m_addr_q <= d_addr;
            m_wdata_q <= d_wdata;
            if (i_req && !starved) cnt_q <= cnt_q + 1'b1;
          end
        end
        REQ: begin
          if (m_gnt) begin
            m_req_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            state_q <= RESP;
            if (owner_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q <= m_we_q ? '0 : m_rdata;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q <= m_rdata;
            end
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TOHOST_MON_EN
  logic full_wr;
  assign full_wr = d_win & d_we & (d_be == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      result <= '0;
    end else begin
      if (full_wr && d_addr == RESULT_ADDR) result <= d_wdata;
      if (full_wr && d_addr == DONE_ADDR &&
          d_wdata == DATA_W'(32'hDEADBEEF)) done <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level model of the
// arbiter checked every cycle, plus hand-computed literal expectations.
module tb_mem_arbiter;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic i_req = 0, i_gnt, i_rvalid;
  logic [31:0] i_addr = 0, i_rdata;
  logic d_req = 0, d_we = 0, d_gnt, d_rvalid;
  logic [3:0] d_be = 0;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic m_req, m_we, m_gnt = 0, m_rvalid = 0;
  logic [3:0] m_be;
  logic [31:0] m_addr, m_wdata, m_rdata = 0;
`ifdef TOHOST_MON_EN
  logic done;
  logic [31:0] result;
`endif

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata)
`ifdef TOHOST_MON_EN
    , .done(done), .result(result)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a transaction is in flight from its grant
  // until the cycle its response is shown.
  bit busy, own_d, mreq_p, waiting, resp;
  logic [31:0] ma, mw, rd;
  logic [3:0] mb;
  logic mwe;
  int starve;
  logic done_m;
  logic [31:0] res_m;

  function automatic bit fwin();
    return !busy && i_req && (!d_req || starve >= SMAX);
  endfunction

  function automatic bit dwin();
    return !busy && d_req && !fwin();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 0; own_d = 0; mreq_p = 0; waiting = 0; resp = 0;
      ma = 0; mw = 0; rd = 0; mb = 0; mwe = 0; starve = 0;
      done_m = 0; res_m = 0;
    end else if (resp) begin
      resp = 0; busy = 0;
    end else if (waiting) begin
      if (m_rvalid) begin waiting = 0; resp = 1; rd = m_rdata; end
    end else if (mreq_p) begin
      if (m_gnt) begin mreq_p = 0; waiting = 1; end
    end else if (fwin()) begin
      busy = 1; own_d = 0; mreq_p = 1;
      ma = i_addr; mwe = 0; mb = 4'hF; mw = 0; starve = 0;
    end else if (dwin()) begin
      busy = 1; own_d = 1; mreq_p = 1;
      ma = d_addr; mwe = d_we; mb = d_be; mw = d_wdata;
      if (i_req && starve < SMAX) starve++;
      if (d_we && d_be == 4'hF) begin
        if (d_addr == 32'h80001000) res_m = d_wdata;
        if (d_addr == 32'h80001004 && d_wdata == 32'hDEADBEEF)
          done_m = 1;
      end
    end
  end

  int i_rv_n = 0, d_rv_n = 0, mreq_cyc = 0;
  logic [31:0] last_i_rdata = 0;
  time tg_i = 0, tg_d = 0, t_drv = 0;
  int dg_n = 0, dg_at_ig = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("i_gnt", i_gnt, fwin());
      chk("d_gnt", d_gnt, dwin());
      chk("m_req", m_req, mreq_p);
      chk("m_addr", m_addr, ma);
      chk("m_we", m_we, mwe);
      chk("m_be", m_be, mb);
      chk("m_wdata", m_wdata, mw);
      chk("i_rvalid", i_rvalid, resp && !own_d);
      chk("i_rdata", i_rdata, (resp && !own_d) ? rd : 0);
      chk("d_rvalid", d_rvalid, resp && own_d);
      chk("d_rdata", d_rdata, (resp && own_d && !mwe) ? rd : 0);
`ifdef TOHOST_MON_EN
      chk("done", done, done_m);
      chk("result", result, res_m);
`endif
      if (i_rvalid) begin i_rv_n++; last_i_rdata = i_rdata; end
      if (d_rvalid) begin d_rv_n++; t_drv = $time; end
      if (m_req) mreq_cyc++;
      if (d_gnt) begin dg_n++; tg_d = $time; end
      if (i_gnt) begin dg_at_ig = dg_n; tg_i = $time; end
    end
  end

  // Memory responder: m_gnt after stall_cfg cycles of m_req, then
  // m_rvalid rv_cfg cycles after the accepting cycle's successor.
  int stall_cfg = 0, rv_cfg = 0, stall_cnt = 0, rv_cnt = 0;
  logic [31:0] rdata_cfg = 0;
  bit gnt_done = 0;

  always @(posedge clk) begin
    #1;
    m_gnt = 0;
    m_rvalid = 0;
    if (gnt_done) begin
      if (rv_cnt >= rv_cfg) begin
        m_rvalid = 1; m_rdata = rdata_cfg; gnt_done = 0; rv_cnt = 0;
      end else rv_cnt++;
    end else if (m_req) begin
      if (stall_cnt >= stall_cfg) begin
        m_gnt = 1; gnt_done = 1; stall_cnt = 0;
      end else stall_cnt++;
    end
  end

  task automatic fetch_req(input logic [31:0] a);
    i_addr = a;
    i_req = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (i_gnt) begin
        @(posedge clk);
        #1 i_req = 0;
        return;
      end
    end
    chk("fetch_gnt_timeout", 0, 1);
    i_req = 0;
  endtask

  task automatic data_req(input logic we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd);
    d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    d_req = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (d_gnt) begin
        @(posedge clk);
        #1 d_req = 0;
        return;
      end
    end
    chk("data_gnt_timeout", 0, 1);
    d_req = 0;
  endtask

  task automatic drain();
    repeat (10) @(posedge clk);
    #1;
  endtask

  int base_i, base_d, base_dg;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    rst = 0;
    drain();

    rdata_cfg = 32'h00000013;
    fetch_req(32'h80000000);
    @(negedge clk);
    chk("f_m_addr", m_addr, 32'h80000000);
    chk("f_m_we", m_we, 0);
    chk("f_m_req", m_req, 1);
    drain();
    chk("f_rv_count", i_rv_n, 1);
    chk("f_rdata", last_i_rdata, 32'h00000013);
    chk("f_d_rv_count", d_rv_n, 0);

    rdata_cfg = 32'hCAFE0001;
    fork
      fetch_req(32'h80000100);
      data_req(0, 4'hF, 32'h80001000, 0);
    join
    drain();
    chk("sim_data_first", tg_d < tg_i, 1);
    chk("sim_latency", 32'(t_drv - tg_d), 30);
    chk("sim_fetch_after", 32'(tg_i - t_drv), 10);

    base_dg = dg_n;
    fork
      fetch_req(32'h80000200);
      for (int k = 0; k < 5; k++) data_req(0, 4'hF, 32'h80001010, 0);
    join
    drain();
    chk("starve_dgnts", dg_at_ig - base_dg, SMAX);
    fork
      fetch_req(32'h80000300);
      data_req(0, 4'hF, 32'h80001020, 0);
    join
    drain();
    chk("starve_cleared", tg_d < tg_i, 1);

    stall_cfg = 3;
    base_d = d_rv_n;
    mreq_cyc = 0;
    data_req(1, 4'h5, 32'h80002000, 32'h1234ABCD);
    drain();
    chk("stall_mreq_cycles", mreq_cyc, 4);
    chk("stall_one_resp", d_rv_n - base_d, 1);
    stall_cfg = 0;

    rv_cfg = 4;
    base_d = d_rv_n;
    base_i = i_rv_n;
    data_req(0, 4'hF, 32'h80001000, 0);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    chk("mid_rst_d_rvalid", d_rvalid, 0);
    @(posedge clk);
    #1 rst = 0;
    drain();
    chk("rst_no_d_resp", d_rv_n - base_d, 0);
    chk("rst_no_i_resp", i_rv_n - base_i, 0);
    rv_cfg = 0;
    rdata_cfg = 32'h00A0B0C0;
    fetch_req(32'h80000400);
    drain();
    chk("post_rst_fetch", i_rv_n - base_i, 1);
    chk("post_rst_rdata", last_i_rdata, 32'h00A0B0C0);

`ifdef TOHOST_MON_EN
    data_req(1, 4'h1, 32'h80001004, 32'hDEADBEEF);
    drain();
    chk("th_partial_done", done, 0);
    data_req(1, 4'hF, 32'h80001000, 32'h2);
    drain();
    chk("th_result", result, 2);
    data_req(1, 4'hF, 32'h80001004, 32'hDEADBEEF);
    drain();
    chk("th_done", done, 1);
    drain();
    chk("th_done_held", done, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory port between the CPU instruction-fetch requester (read-only) and the load/store requester (read/write).
- Runs a one-outstanding-transaction state machine with fixed data-over-fetch priority and a starvation guard so fetch is never locked out.
- Sits between the core and the memory inside top.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins the next contested arbitration.
- DONE_ADDR, 32'h80001004, done-flag address (used only with TOHOST_MON_EN).
- RESULT_ADDR, 32'h80001000, result address (used only with TOHOST_MON_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  one-cycle pulse: fetch request captured.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle pulse: data request captured.
- d_rvalid  out  1  one-cycle pulse: read data valid or write completed.
- d_rdata  out  DATA_W  load data; 0 for writes.
- m_req  out  1  memory request; held until m_gnt.
- m_we, m_be, m_addr, m_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered copy of the winning request.
- m_gnt  in  1  memory accepted m_req this cycle.
- m_rvalid  in  1  memory response (read data or write ack).
- m_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, owner = none, starve counter 0.
- States: IDLE -> REQ -> WAIT -> RESP -> IDLE.
- IDLE arbitration:
  - No request: stay in IDLE.
  - Single request: that requester wins.
  - Both requesting: data wins unless starve counter == STARVE_MAX, in which case fetch wins.
- On a win at cycle N:
  - Pulse the winner's gnt at cycle N.
  - Latch the winner's fields and owner into m_* registers (fetch forces m_we=0 and m_be all ones).
  - Go to REQ; m_req is high from cycle N+1.
- REQ: hold m_req and all m_* stable until m_gnt is sampled high, then drop m_req and go to WAIT.
- WAIT: on m_rvalid, register m_rdata to the owner's rdata and go to RESP.
- RESP: pulse the owner's rvalid for exactly one cycle, then go to IDLE. The earliest next grant is the following cycle.
- Minimum latency, gnt to rvalid: 3 cycles (with m_gnt in the first REQ cycle and m_rvalid in the first WAIT cycle).
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each data grant while i_req is high.
  - Clears on every fetch grant.
- Requests that arrive while not in IDLE are not acknowledged; requesters keep req high.
- m_rvalid while in IDLE or REQ is ignored; no output changes.
- Non-owner rvalid and rdata stay 0.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight response is discarded and is never delivered to either requester.

Optional Feature:
- Macro: TOHOST_MON_EN.
- Defined:
  - Adds outputs done (1 bit) and result (DATA_W).
  - On a data write grant with d_be all ones and d_addr == RESULT_ADDR, result <= d_wdata on the next edge.
  - On a data write grant with d_be all ones, d_addr == DONE_ADDR and d_wdata == 32'hDEADBEEF, done goes high on the next edge and stays high until rst.
  - Both outputs reset to 0.
  - The write still proceeds to memory normally.
- Undefined: done and result ports are absent; no monitoring logic.

Test Plan:
- Fetch only: i_req with i_addr=0x80000000; m_rvalid with m_rdata=0x00000013 one cycle after m_gnt -> i_gnt at N, m_addr=0x80000000 with m_we=0 at N+1, i_rvalid with i_rdata=0x00000013 exactly once, d_rvalid stays 0.
- Simultaneous: i_req and d_req (read at 0x80001000) in the same cycle -> d_gnt first, m_addr=0x80001000; i_gnt in the first IDLE cycle after d_rvalid.
- Starvation: i_req held high; d_req re-asserted continuously with STARVE_MAX=4 -> 4 data grants, then i_gnt on the 5th contested arbitration, counter back to 0.
- m_gnt stalled 3 cycles -> m_req and m_addr/m_wdata/m_be stable across all stall cycles; exactly one response is delivered.
- rst pulsed while in WAIT, followed by m_rvalid -> all outputs 0, no i_rvalid or d_rvalid; the next request is arbitrated normally.
- TOHOST_MON_EN: write 2 to 0x80001000, then write 0xDEADBEEF to 0x80001004, both with be=4'hF -> result=2, done=1 and held; a write of 0xDEADBEEF with be=4'h1 leaves done=0.
